// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer for a single PE datapath.
//
// Flow of a job: the filter is loaded into the filter scratchpad once. After that,
// each output refills the circular IF scratchpad with fresh elements, runs the MAC
// loop over the sliding window, and writes the partial sum to the output buffer.
//
// Optional feature: define PE_CTRL_PSUM_ACC_EN to add a PSUM state. In that state an
// incoming partial sum is read from the psum buffer and added before the write-back.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start                             begin a job (sampled only in IDLE)
//   cfg_filt_len/cfg_stride/cfg_num_out   F, S and N, latched on start
//   filt_buf_empty -> filt_buf_rd, filt_sc_wen, filt_sc_waddr   filter load
//   if_buf_empty   -> if_buf_rd, if_sc_wen, if_sc_waddr         IF load
//   filt_sc_raddr, if_sc_raddr, mac_en, psum_clr                MAC loop
//   out_buf_full   -> out_buf_wr                                psum write-back
//   psum_buf_empty -> psum_buf_rd, psum_ld                      (PE_CTRL_PSUM_ACC_EN only)
//   busy, done                        status; done is a one-cycle pulse
module pe_ctrl #(
  parameter int unsigned FILT_ADDR_LEN      = 4,
  parameter int unsigned IF_ADDR_LEN        = 4,
  parameter int unsigned FILT_SCRATCH_DEPTH = 16,
  parameter int unsigned IF_SCRATCH_DEPTH   = 16,
  parameter int unsigned CNT_LEN            = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FILT_ADDR_LEN:0]   cfg_filt_len,
  input  logic [IF_ADDR_LEN-1:0]   cfg_stride,
  input  logic [CNT_LEN-1:0]       cfg_num_out,
  input  logic                     filt_buf_empty,
  output logic                     filt_buf_rd,
  output logic                     filt_sc_wen,
  output logic [FILT_ADDR_LEN-1:0] filt_sc_waddr,
  input  logic                     if_buf_empty,
  output logic                     if_buf_rd,
  output logic                     if_sc_wen,
  output logic [IF_ADDR_LEN-1:0]   if_sc_waddr,
  output logic [FILT_ADDR_LEN-1:0] filt_sc_raddr,
  output logic [IF_ADDR_LEN-1:0]   if_sc_raddr,
  output logic                     mac_en,
  output logic                     psum_clr,
  input  logic                     out_buf_full,
  output logic                     out_buf_wr,
`ifdef PE_CTRL_PSUM_ACC_EN
  input  logic                     psum_buf_empty,
  output logic                     psum_buf_rd,
  output logic                     psum_ld,
`endif
  output logic                     busy,
  output logic                     done
);

  // Scratchpad depths must fit their address widths.
  if (FILT_SCRATCH_DEPTH < 1 || FILT_SCRATCH_DEPTH > (1 << FILT_ADDR_LEN)) begin : g_bad_filt
    $error("FILT_SCRATCH_DEPTH does not fit FILT_ADDR_LEN");
  end
  if (IF_SCRATCH_DEPTH < 1 || IF_SCRATCH_DEPTH > (1 << IF_ADDR_LEN)) begin : g_bad_if
    $error("IF_SCRATCH_DEPTH does not fit IF_ADDR_LEN");
  end

  localparam int unsigned FW = FILT_ADDR_LEN + 1;  // holds F itself
  localparam int unsigned NW = IF_ADDR_LEN + 1;    // holds F or S as a refill count
  localparam int unsigned SW = IF_ADDR_LEN + 2;    // holds a sum of two values below depth
  localparam logic [SW-1:0] IfDepth = SW'(IF_SCRATCH_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLdFilt,
    StLdIf,
    StMac,
`ifdef PE_CTRL_PSUM_ACC_EN
    StPsum,
`endif
    StWr,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [FW-1:0]          filt_len_q, filt_len_d;
  logic [IF_ADDR_LEN-1:0] stride_q, stride_d;
  logic [CNT_LEN-1:0]     num_out_q, num_out_d;
  logic [FW-1:0]          k_q, k_d;            // filter words loaded
  logic [FW-1:0]          j_q, j_d;            // MAC tap index
  logic [NW-1:0]          if_cnt_q, if_cnt_d;  // IF words loaded in this refill
  logic [NW-1:0]          need_q, need_d;      // IF words required by this refill
  logic [IF_ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [IF_ADDR_LEN-1:0] base_q, base_d;      // window start in the circular IF pad
  logic [CNT_LEN-1:0]     out_cnt_q, out_cnt_d;

  // Operands are always below 2*depth, so a single conditional subtract wraps them.
  function automatic logic [IF_ADDR_LEN-1:0] if_wrap(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = (v >= IfDepth) ? (v - IfDepth) : v;
    return IF_ADDR_LEN'(r);
  endfunction

  always_comb begin
    state_d       = state_q;
    filt_len_d    = filt_len_q;
    stride_d      = stride_q;
    num_out_d     = num_out_q;
    k_d           = k_q;
    j_d           = j_q;
    if_cnt_d      = if_cnt_q;
    need_d        = need_q;
    wr_ptr_d      = wr_ptr_q;
    base_d        = base_q;
    out_cnt_d     = out_cnt_q;
    filt_buf_rd   = 1'b0;
    filt_sc_wen   = 1'b0;
    filt_sc_waddr = '0;
    if_buf_rd     = 1'b0;
    if_sc_wen     = 1'b0;
    if_sc_waddr   = '0;
    filt_sc_raddr = '0;
    if_sc_raddr   = '0;
    mac_en        = 1'b0;
    psum_clr      = 1'b0;
    out_buf_wr    = 1'b0;
`ifdef PE_CTRL_PSUM_ACC_EN
    psum_buf_rd   = 1'b0;
    psum_ld       = 1'b0;
`endif
    done          = 1'b0;
    busy          = (state_q != StIdle) && (state_q != StDone);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          filt_len_d = cfg_filt_len;
          stride_d   = cfg_stride;
          num_out_d  = cfg_num_out;
          k_d        = '0;
          j_d        = '0;
          if_cnt_d   = '0;
          need_d     = '0;
          wr_ptr_d   = '0;
          base_d     = '0;
          out_cnt_d  = '0;
          state_d    = (cfg_num_out == '0) ? StDone : StLdFilt;
        end
      end
      StLdFilt: begin
        if (!filt_buf_empty) begin
          filt_buf_rd   = 1'b1;
          filt_sc_wen   = 1'b1;
          filt_sc_waddr = k_q[FILT_ADDR_LEN-1:0];
          k_d           = k_q + 1'b1;
          if (k_q + 1'b1 == filt_len_q) begin
            need_d  = NW'(filt_len_q);
            state_d = StLdIf;
          end
        end
      end
      StLdIf: begin
        if (!if_buf_empty) begin
          if_buf_rd   = 1'b1;
          if_sc_wen   = 1'b1;
          if_sc_waddr = wr_ptr_q;
          wr_ptr_d    = if_wrap(SW'(wr_ptr_q) + SW'(1));
          if_cnt_d    = if_cnt_q + 1'b1;
          if (if_cnt_q + 1'b1 == need_q) begin
            if_cnt_d = '0;
            j_d      = '0;
            state_d  = StMac;
          end
        end
      end
      StMac: begin
        mac_en        = 1'b1;
        psum_clr      = (j_q == '0);
        filt_sc_raddr = j_q[FILT_ADDR_LEN-1:0];
        if_sc_raddr   = if_wrap(SW'(base_q) + SW'(j_q));
        j_d           = j_q + 1'b1;
        if (j_q == filt_len_q - 1'b1) begin
`ifdef PE_CTRL_PSUM_ACC_EN
          state_d = StPsum;
`else
          state_d = StWr;
`endif
        end
      end
`ifdef PE_CTRL_PSUM_ACC_EN
      StPsum: begin
        if (!psum_buf_empty) begin
          psum_buf_rd = 1'b1;
          psum_ld     = 1'b1;
          state_d     = StWr;
        end
      end
`endif
      StWr: begin
        if (!out_buf_full) begin
          out_buf_wr = 1'b1;
          out_cnt_d  = out_cnt_q + 1'b1;
          if (out_cnt_q + 1'b1 == num_out_q) begin
            state_d = StDone;
          end else begin
            base_d  = if_wrap(SW'(base_q) + SW'(stride_q));
            need_d  = NW'(stride_q);
            state_d = StLdIf;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      filt_len_q <= '0;
      stride_q   <= '0;
      num_out_q  <= '0;
      k_q        <= '0;
      j_q        <= '0;
      if_cnt_q   <= '0;
      need_q     <= '0;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      filt_len_q <= filt_len_d;
      stride_q   <= stride_d;
      num_out_q  <= num_out_d;
      k_q        <= k_d;
      j_q        <= j_d;
      if_cnt_q   <= if_cnt_d;
      need_q     <= need_d;
      wr_ptr_q   <= wr_ptr_d;
      base_q     <= base_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// Bench for pe_ctrl. Two instances share all inputs: one with 16-entry scratchpads and
// one with a 4-entry IF scratchpad (wrap modulus 4). The reference model expands a job
// into the ordered list of operations it must perform; each cycle, the head operation
// either issues (if its buffer is ready) or stalls.
module tb_pe_ctrl;
  localparam int FL = 4;
  localparam int IL = 4;
  localparam int CL = 8;
`ifdef PE_CTRL_PSUM_ACC_EN
  localparam int PsumX = 1;
`else
  localparam int PsumX = 0;
`endif
  localparam int KFilt = 0, KIf = 1, KMac = 2, KPsum = 3, KWr = 4, KDone = 5;

  typedef struct packed {
    logic       filt_rd;
    logic       filt_wen;
    logic [3:0] filt_waddr;
    logic       if_rd;
    logic       if_wen;
    logic [3:0] if_waddr;
    logic [3:0] filt_raddr;
    logic [3:0] if_raddr;
    logic       mac_en;
    logic       psum_clr;
    logic       out_wr;
    logic       psum_rd;
    logic       psum_ld;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int kind;
    int a;    // filter address / tap index
    int b;    // unwrapped IF element index
    bit clr;
  } step_t;

  typedef struct {
    int f, s, n;
    int done_at, fw, iw, mac, ow;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [FL:0]   cfg_filt_len;
  logic [IL-1:0] cfg_stride;
  logic [CL-1:0] cfg_num_out;
  logic filt_buf_empty, if_buf_empty, out_buf_full, psum_buf_empty;
  obs_t obs [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          filt_buf_rd, filt_sc_wen, if_buf_rd, if_sc_wen;
    logic [FL-1:0] filt_sc_waddr, filt_sc_raddr;
    logic [IL-1:0] if_sc_waddr, if_sc_raddr;
    logic          mac_en, psum_clr, out_buf_wr, psum_buf_rd, psum_ld, busy, done;

    pe_ctrl #(
      .FILT_ADDR_LEN     (FL),
      .IF_ADDR_LEN       (IL),
      .FILT_SCRATCH_DEPTH((g == 0) ? 16 : 4),
      .IF_SCRATCH_DEPTH  ((g == 0) ? 16 : 4),
      .CNT_LEN           (CL)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cfg_filt_len  (cfg_filt_len),
      .cfg_stride    (cfg_stride),
      .cfg_num_out   (cfg_num_out),
      .filt_buf_empty(filt_buf_empty),
      .filt_buf_rd   (filt_buf_rd),
      .filt_sc_wen   (filt_sc_wen),
      .filt_sc_waddr (filt_sc_waddr),
      .if_buf_empty  (if_buf_empty),
      .if_buf_rd     (if_buf_rd),
      .if_sc_wen     (if_sc_wen),
      .if_sc_waddr   (if_sc_waddr),
      .filt_sc_raddr (filt_sc_raddr),
      .if_sc_raddr   (if_sc_raddr),
      .mac_en        (mac_en),
      .psum_clr      (psum_clr),
      .out_buf_full  (out_buf_full),
      .out_buf_wr    (out_buf_wr),
`ifdef PE_CTRL_PSUM_ACC_EN
      .psum_buf_empty(psum_buf_empty),
      .psum_buf_rd   (psum_buf_rd),
      .psum_ld       (psum_ld),
`endif
      .busy          (busy),
      .done          (done)
    );
`ifndef PE_CTRL_PSUM_ACC_EN
    assign psum_buf_rd = 1'b0;
    assign psum_ld     = 1'b0;
`endif
    assign obs[g] = {filt_buf_rd, filt_sc_wen, filt_sc_waddr, if_buf_rd, if_sc_wen,
                     if_sc_waddr, filt_sc_raddr, if_sc_raddr, mac_en, psum_clr, out_buf_wr,
                     psum_buf_rd, psum_ld, busy, done};
  end

  int n_checks = 0;
  int n_fail   = 0;
  step_t q[$];
  int done_cyc, n_fw, n_iw, n_mac, n_ow, n_ps;
  int w4[$];
  int r4[$];

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %p, expected %p", name, act, exp);
    end
  endtask

  // Addresses only carry meaning while their strobe is high.
  function automatic obs_t mask(input obs_t o);
    obs_t r = o;
    if (!o.filt_wen) r.filt_waddr = '0;
    if (!o.if_wen) r.if_waddr = '0;
    if (!o.mac_en) begin
      r.filt_raddr = '0;
      r.if_raddr   = '0;
    end
    return r;
  endfunction

  // A job as a flat list of operations: filter load, then per output an IF refill
  // (F elements first, S afterwards), F taps over window o*S.., optional psum, write.
  function automatic void build(input int f, input int s, input int n);
    int wp = 0;
    q.delete();
    if (n > 0) begin
      for (int k = 0; k < f; k++) q.push_back('{KFilt, k, 0, 1'b0});
      for (int o = 0; o < n; o++) begin
        for (int i = 0; i < ((o == 0) ? f : s); i++) begin
          q.push_back('{KIf, 0, wp, 1'b0});
          wp++;
        end
        for (int j = 0; j < f; j++) q.push_back('{KMac, j, o * s + j, (j == 0)});
        if (PsumX == 1) q.push_back('{KPsum, 0, 0, 1'b0});
        q.push_back('{KWr, 0, 0, 1'b0});
      end
    end
    q.push_back('{KDone, 0, 0, 1'b0});
  endfunction

  function automatic obs_t expect_obs(input step_t h, input bit stl, input int d);
    obs_t e = '0;
    e.busy = (h.kind != KDone);
    if (!stl) begin
      case (h.kind)
        KFilt: begin e.filt_rd = 1'b1; e.filt_wen = 1'b1; e.filt_waddr = 4'(h.a); end
        KIf:   begin e.if_rd = 1'b1; e.if_wen = 1'b1; e.if_waddr = 4'(h.b % d); end
        KMac: begin
          e.mac_en     = 1'b1;
          e.filt_raddr = 4'(h.a);
          e.if_raddr   = 4'(h.b % d);
          e.psum_clr   = h.clr;
        end
        KPsum: begin e.psum_rd = 1'b1; e.psum_ld = 1'b1; end
        KWr:   e.out_wr = 1'b1;
        KDone: e.done = 1'b1;
        default: ;
      endcase
    end
    return e;
  endfunction

  // Entered and left at #1 after a rising edge. mode: 0 no stalls, 1 random stalls,
  // 2 scripted IF/out stalls, 3 scripted psum stall. abort_at: cycle to raise rst (-1 none).
  task automatic run_job(input int f, input int s, input int n, input int mode,
                         input int pct, input int abort_at);
    int  cyc = 1;
    bit  fin = 1'b0;
    bit  chk4 = (f <= 4);
    bit  stl;
    build(f, s, n);
    done_cyc = -1;
    n_fw = 0; n_iw = 0; n_mac = 0; n_ow = 0; n_ps = 0;
    w4.delete();
    r4.delete();
    start = 1'b1;
    cfg_filt_len = (FL + 1)'(f);
    cfg_stride = IL'(s);
    cfg_num_out = CL'(n);
    filt_buf_empty = 1'b0; if_buf_empty = 1'b0; out_buf_full = 1'b0; psum_buf_empty = 1'b0;
    @(negedge clk);
    check_obs("idle_at_start", mask(obs[0]), '0);
    @(posedge clk); #1;
    while (!fin) begin
      if (cyc > 3000) begin
        check_int("job_timeout", cyc, -1);
        break;
      end
      // start and config are noise once the job is running
      start = 1'($urandom_range(1));
      cfg_filt_len = (FL + 1)'($urandom);
      cfg_stride = IL'($urandom);
      cfg_num_out = CL'($urandom);
      case (mode)
        1: begin
          filt_buf_empty = (int'($urandom_range(99)) < pct);
          if_buf_empty   = (int'($urandom_range(99)) < pct);
          out_buf_full   = (int'($urandom_range(99)) < pct);
          psum_buf_empty = (int'($urandom_range(99)) < pct);
        end
        2: begin
          if_buf_empty = (cyc == 5 || cyc == 6);
          out_buf_full = (cyc >= 12 + PsumX && cyc <= 14 + PsumX);
        end
        3: psum_buf_empty = (cyc == 7 || cyc == 8);
        default: ;
      endcase
      if (cyc == abort_at) rst = 1'b1;
      @(negedge clk);
      stl = (q[0].kind == KFilt && filt_buf_empty) || (q[0].kind == KIf && if_buf_empty) ||
            (q[0].kind == KWr && out_buf_full) || (q[0].kind == KPsum && psum_buf_empty);
      check_obs($sformatf("cycle%0d_d16", cyc), mask(obs[0]), expect_obs(q[0], stl, 16));
      if (chk4)
        check_obs($sformatf("cycle%0d_d4", cyc), mask(obs[1]), expect_obs(q[0], stl, 4));
      n_fw += int'(obs[0].filt_wen);
      n_iw += int'(obs[0].if_wen);
      n_mac += int'(obs[0].mac_en);
      n_ow += int'(obs[0].out_wr);
      n_ps += int'(obs[0].psum_rd);
      if (obs[0].done) done_cyc = cyc;
      if (obs[1].if_wen) w4.push_back(int'(obs[1].if_waddr));
      if (obs[1].mac_en) r4.push_back(int'(obs[1].if_raddr));
      if (!stl) begin
        if (q[0].kind == KDone) fin = 1'b1;
        void'(q.pop_front());
      end
      if (cyc == abort_at) fin = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    filt_buf_empty = 1'b0; if_buf_empty = 1'b0; out_buf_full = 1'b0; psum_buf_empty = 1'b0;
    if (abort_at < 0) begin
      @(negedge clk);
      check_obs("idle_after_job", mask(obs[0]), '0);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[7];
  int   exp_w[7];
  int   exp_r[9];

  initial begin
    // F, S, N, done cycle (no psum stage), filter writes, IF writes, MACs, out writes
    tbl[0] = '{3, 1, 2, 16, 3, 4, 6, 2};
    tbl[1] = '{1, 1, 1, 5, 1, 1, 1, 1};
    tbl[2] = '{4, 2, 3, 28, 4, 8, 12, 3};
    tbl[3] = '{16, 16, 1, 50, 16, 16, 16, 1};
    tbl[4] = '{16, 1, 3, 86, 16, 18, 48, 3};
    tbl[5] = '{2, 2, 0, 1, 0, 0, 0, 0};
    tbl[6] = '{4, 4, 2, 23, 4, 8, 8, 2};
    exp_w = '{0, 1, 2, 3, 0, 1, 2};
    exp_r = '{0, 1, 2, 2, 3, 0, 0, 1, 2};

    rst = 1'b1; start = 1'b0;
    cfg_filt_len = '0; cfg_stride = '0; cfg_num_out = '0;
    filt_buf_empty = 1'b0; if_buf_empty = 1'b0; out_buf_full = 1'b0; psum_buf_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_obs("reset_d16", obs[0], '0);
    check_obs("reset_d4", obs[1], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_obs("idle_after_reset", obs[0], '0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i].f, tbl[i].s, tbl[i].n, 0, 0, -1);
      check_int($sformatf("vec%0d_done_cycle", i), done_cyc, tbl[i].done_at + PsumX * tbl[i].n);
      check_int($sformatf("vec%0d_filt_writes", i), n_fw, tbl[i].fw);
      check_int($sformatf("vec%0d_if_writes", i), n_iw, tbl[i].iw);
      check_int($sformatf("vec%0d_macs", i), n_mac, tbl[i].mac);
      check_int($sformatf("vec%0d_out_writes", i), n_ow, tbl[i].ow);
    end

    // Wrap in a 4-entry IF scratchpad
    run_job(3, 2, 3, 0, 0, -1);
    check_int("wrap_if_write_count", w4.size(), 7);
    for (int i = 0; i < 7 && i < w4.size(); i++)
      check_int($sformatf("wrap_if_waddr%0d", i), w4[i], exp_w[i]);
    check_int("wrap_mac_count", r4.size(), 9);
    for (int i = 0; i < 9 && i < r4.size(); i++)
      check_int($sformatf("wrap_if_raddr%0d", i), r4[i], exp_r[i]);

    // 2 IF-empty cycles plus 3 out-full cycles delay done by 5
    run_job(3, 1, 2, 2, 0, -1);
    check_int("stall_done_cycle", done_cyc, 21 + 2 * PsumX);

    // Reset while the MAC loop is at j=1
    run_job(3, 1, 2, 0, 0, 8);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_obs($sformatf("after_abort%0d_d16", i), obs[0], '0);
      check_obs($sformatf("after_abort%0d_d4", i), obs[1], '0);
      @(posedge clk); #1;
    end
    run_job(3, 1, 2, 0, 0, -1);
    check_int("rerun_done_cycle", done_cyc, 16 + 2 * PsumX);
    check_int("rerun_out_writes", n_ow, 2);

`ifdef PE_CTRL_PSUM_ACC_EN
    run_job(2, 1, 1, 3, 0, -1);
    check_int("psum_done_cycle", done_cyc, 11);
    check_int("psum_reads", n_ps, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      int f = int'($urandom_range(16, 1));
      int s = int'($urandom_range(f, 1));
      int n = int'($urandom_range(4, 0));
      run_job(f, s, n, 1, 30, -1);
      check_int($sformatf("rand%0d_out_writes", i), n_ow, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
